// File: rtl/reg12_universal.sv
// 12-bit universal register: load/hold/inc/dec in one cycle, shift/rotate
// one bit per clock, with a busy/done handshake for back-to-back sequencing.
module reg12_universal #(
  parameter int unsigned WIDTH = 12,
  parameter int unsigned AMT_W = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] din,
  input  logic [AMT_W-1:0] sh_amt,
  input  logic             ser_in,
  output logic [WIDTH-1:0] q,
  output logic             carry,
  output logic             busy,
  output logic             done
);

  localparam logic [2:0] OP_HOLD = 3'b000;
  localparam logic [2:0] OP_LOAD = 3'b001;
  localparam logic [2:0] OP_SHL  = 3'b010;
  localparam logic [2:0] OP_SHR  = 3'b011;
  localparam logic [2:0] OP_ROL  = 3'b100;
  localparam logic [2:0] OP_ROR  = 3'b101;
  localparam logic [2:0] OP_INC  = 3'b110;
  localparam logic [2:0] OP_DEC  = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] w_q_nxt;
  logic             r_carry;
  logic             w_carry_nxt;
  logic [AMT_W-1:0] r_cnt;
  logic [AMT_W-1:0] w_cnt_nxt;
  logic [2:0]       r_op;
  logic [2:0]       w_op_nxt;
  logic             r_busy;
  logic             r_done;

  // State and datapath registers; busy/done registered from the next state.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
      r_q     <= '0;
      r_carry <= 1'b0;
      r_cnt   <= '0;
      r_op    <= OP_HOLD;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_q     <= w_q_nxt;
      r_carry <= w_carry_nxt;
      r_cnt   <= w_cnt_nxt;
      r_op    <= w_op_nxt;
      r_busy  <= (w_state_nxt != ST_IDLE);
      r_done  <= (w_state_nxt == ST_DONE);
    end
  end

  // Next-state and datapath update.
  always_comb begin
    w_state_nxt = r_state;
    w_q_nxt     = r_q;
    w_carry_nxt = r_carry;
    w_cnt_nxt   = r_cnt;
    w_op_nxt    = r_op;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_op_nxt    = op;
          w_carry_nxt = 1'b0;
          w_state_nxt = ST_DONE;
          case (op)
            OP_HOLD: ;
            OP_LOAD: w_q_nxt = din;
            OP_INC: begin
              w_q_nxt     = r_q + WIDTH'(1);
              w_carry_nxt = &r_q;
            end
            OP_DEC: begin
              w_q_nxt     = r_q - WIDTH'(1);
              w_carry_nxt = ~|r_q;
            end
            default: begin
              // Shift/rotate: a zero amount completes immediately with no change.
              if (sh_amt != '0) begin
                w_cnt_nxt   = sh_amt;
                w_state_nxt = ST_RUN;
              end
            end
          endcase
        end
      end
      ST_RUN: begin
        w_cnt_nxt = r_cnt - AMT_W'(1);
        if (r_cnt == AMT_W'(1)) begin
          w_state_nxt = ST_DONE;
        end
        case (r_op)
          OP_SHL: begin
            w_q_nxt     = {r_q[WIDTH-2:0], ser_in};
            w_carry_nxt = r_q[WIDTH-1];
          end
          OP_SHR: begin
            w_q_nxt     = {ser_in, r_q[WIDTH-1:1]};
            w_carry_nxt = r_q[0];
          end
          OP_ROL: begin
            w_q_nxt     = {r_q[WIDTH-2:0], r_q[WIDTH-1]};
            w_carry_nxt = r_q[WIDTH-1];
          end
          OP_ROR: begin
            w_q_nxt     = {r_q[0], r_q[WIDTH-1:1]};
            w_carry_nxt = r_q[0];
          end
          default: ;
        endcase
      end
      ST_DONE: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign q     = r_q;
  assign carry = r_carry;
  assign busy  = r_busy;
  assign done  = r_done;

endmodule

// File: tb/tb_reg12_universal.sv
// Scoreboard bench for reg12_universal: stimulus pushes expected results,
// a monitor pops and compares on every done pulse.
module tb_reg12_universal;

  localparam logic [2:0] OP_HOLD = 3'b000;
  localparam logic [2:0] OP_LOAD = 3'b001;
  localparam logic [2:0] OP_SHL  = 3'b010;
  localparam logic [2:0] OP_SHR  = 3'b011;
  localparam logic [2:0] OP_ROL  = 3'b100;
  localparam logic [2:0] OP_ROR  = 3'b101;
  localparam logic [2:0] OP_INC  = 3'b110;
  localparam logic [2:0] OP_DEC  = 3'b111;

  typedef struct {
    string      name;
    logic [11:0] q;
    logic        c;
    int          busy_cycles;
  } exp_t;

  logic        clk;
  logic        reset_n;
  logic        start;
  logic [2:0]  op;
  logic [11:0] din;
  logic [3:0]  sh_amt;
  logic        ser_in;
  logic [11:0] q;
  logic        carry;
  logic        busy;
  logic        done;

  int   errors = 0;
  int   checks = 0;
  int   busy_cnt = 0;
  exp_t sb[$];

  reg12_universal dut (
    .clk    (clk),
    .reset_n(reset_n),
    .start  (start),
    .op     (op),
    .din    (din),
    .sh_amt (sh_amt),
    .ser_in (ser_in),
    .q      (q),
    .carry  (carry),
    .busy   (busy),
    .done   (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Monitor: sample on the falling edge, compare on every done pulse.
  always @(negedge clk) begin
    if (!reset_n) begin
      busy_cnt = 0;
    end else begin
      if (busy) busy_cnt++;
      if (done) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done: actual q=%0h with no pending op", q);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check({e.name, "_q"}, int'(q), int'(e.q));
          check({e.name, "_carry"}, int'(carry), int'(e.c));
          check({e.name, "_busy_cycles"}, busy_cnt, e.busy_cycles);
        end
        busy_cnt = 0;
      end
    end
  end

  // Issue one op from IDLE and wait (bounded) for it to complete.
  task automatic do_op(input string name, input logic [2:0] o, input logic [11:0] d,
                       input logic [3:0] n, input logic [15:0] ser_pat,
                       input logic [11:0] eq, input logic ec, input int eb,
                       input bit inject);
    exp_t e;
    bit   finished;
    e.name = name; e.q = eq; e.c = ec; e.busy_cycles = eb;
    @(negedge clk);
    start = 1'b1; op = o; din = d; sh_amt = n;
    sb.push_back(e);
    @(posedge clk); #1;
    start = 1'b0; op = OP_DEC; din = 12'h000; sh_amt = 4'hF;
    finished = 1'b0;
    for (int i = 0; i < 40; i++) begin
      ser_in = (i < 16) ? ser_pat[i] : 1'b0;
      if (inject && i == 1) begin
        start = 1'b1; op = OP_LOAD; din = 12'hFFF; sh_amt = 4'h0;
      end
      if (inject && i == 2) start = 1'b0;
      @(posedge clk); #1;
      if (!busy) begin
        finished = 1'b1;
        break;
      end
    end
    start = 1'b0;
    if (!finished) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: actual busy=%0b required busy=0 within 40 cycles", name, busy);
    end
  endtask

  initial begin
    reset_n = 1'b0; start = 1'b0; op = OP_HOLD; din = '0; sh_amt = '0; ser_in = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_q", int'(q), 0);
    check("reset_carry", int'(carry), 0);
    check("reset_busy", int'(busy), 0);
    check("reset_done", int'(done), 0);
    @(negedge clk); reset_n = 1'b1;

    do_op("load_a5c", OP_LOAD, 12'hA5C, 4'd0, 16'h0, 12'hA5C, 1'b0, 1, 1'b0);

    // Reset in the middle of a ROL by 8, after three steps.
    @(negedge clk);
    start = 1'b1; op = OP_ROL; sh_amt = 4'd8;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #2 reset_n = 1'b0;
    #1;
    check("midop_reset_q", int'(q), 0);
    check("midop_reset_carry", int'(carry), 0);
    check("midop_reset_busy", int'(busy), 0);
    check("midop_reset_done", int'(done), 0);
    sb.delete();
    repeat (2) @(negedge clk);
    reset_n = 1'b1;

    do_op("load_a5c_2", OP_LOAD, 12'hA5C, 4'd0, 16'h0, 12'hA5C, 1'b0, 1, 1'b0);
    do_op("shl4_ser1", OP_SHL, 12'h000, 4'd4, 16'hFFFF, 12'h5CF, 1'b0, 5, 1'b0);
    do_op("load_fff", OP_LOAD, 12'hFFF, 4'd0, 16'h0, 12'hFFF, 1'b0, 1, 1'b0);
    do_op("inc_wrap", OP_INC, 12'h000, 4'd0, 16'h0, 12'h000, 1'b1, 1, 1'b0);
    do_op("dec_borrow", OP_DEC, 12'h000, 4'd0, 16'h0, 12'hFFF, 1'b1, 1, 1'b0);
    do_op("load_123", OP_LOAD, 12'h123, 4'd0, 16'h0, 12'h123, 1'b0, 1, 1'b0);
    do_op("inc_123", OP_INC, 12'h000, 4'd0, 16'h0, 12'h124, 1'b0, 1, 1'b0);
    do_op("load_123_2", OP_LOAD, 12'h123, 4'd0, 16'h0, 12'h123, 1'b0, 1, 1'b0);
    do_op("ror12", OP_ROR, 12'h000, 4'd12, 16'h0, 12'h123, 1'b0, 13, 1'b0);
    do_op("shr15_ser0", OP_SHR, 12'h000, 4'd15, 16'h0, 12'h000, 1'b0, 16, 1'b0);
    do_op("load_00d", OP_LOAD, 12'h00D, 4'd0, 16'h0, 12'h00D, 1'b0, 1, 1'b0);
    do_op("shr3_ignore_start", OP_SHR, 12'h000, 4'd3, 16'h0, 12'h001, 1'b1, 4, 1'b1);
    do_op("shl0", OP_SHL, 12'h000, 4'd0, 16'hFFFF, 12'h001, 1'b0, 1, 1'b0);
    do_op("load_000", OP_LOAD, 12'h000, 4'd0, 16'h0, 12'h000, 1'b0, 1, 1'b0);
    do_op("shl3_live_ser", OP_SHL, 12'h000, 4'd3, 16'h0005, 12'h005, 1'b0, 4, 1'b0);
    do_op("hold", OP_HOLD, 12'hFFF, 4'd0, 16'h0, 12'h005, 1'b0, 1, 1'b0);
    do_op("load_801", OP_LOAD, 12'h801, 4'd0, 16'h0, 12'h801, 1'b0, 1, 1'b0);
    do_op("rol1", OP_ROL, 12'h000, 4'd1, 16'h0, 12'h003, 1'b1, 2, 1'b0);

    repeat (3) @(posedge clk);
    #1;
    check("scoreboard_drained", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
